bcd_time_counter: RTL

// - HH:MM:SS BCD timekeeping core of the digital clock; sits directly downstream of the 4-bit CLA.
// - Each BCD digit's "+1" comes from a CLA4 instance (a=digit, b=4'd0, cin=1); this block registers and decimal-adjusts the sums.
// - Advances on an external 1 Hz tick enable; a set-mode FSM lets the user adjust fields.
// - Feeds the display/7-seg decode stage.

---
 rtl/bcd_time_counter_if.sv | 43 ++++
 rtl/bcd_time_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter_if.sv
// Control and time-readout bundle of the HH:MM:SS core.
// pm is present only when TWELVE_HOUR_EN is defined.
interface bcd_time_counter_if;
  logic       tick_1hz;
  logic       set_mode;
  logic [1:0] set_sel;
  logic       set_inc;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       day_rollover;
`ifdef TWELVE_HOUR_EN
  logic       pm;
`endif

  modport master (
    output tick_1hz,
    output set_mode,
    output set_sel,
    output set_inc,
    input  hh,
    input  mm,
    input  ss,
    input  day_rollover
`ifdef TWELVE_HOUR_EN
    , input pm
`endif
  );

  modport slave (
    input  tick_1hz,
    input  set_mode,
    input  set_sel,
    input  set_inc,
    output hh,
    output mm,
    output ss,
    output day_rollover
`ifdef TWELVE_HOUR_EN
    , output pm
`endif
  );
endinterface

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD timekeeping core with RUN/SET mode.
// Optional macro TWELVE_HOUR_EN selects 12-hour mode with pm.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // lookahead carries, all derived from g/p and cin
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module bcd_time_counter #(
  parameter logic [7:0] INIT_HH = 8'h00,
  parameter logic [7:0] INIT_MM = 8'h00,
  parameter logic [7:0] INIT_SS = 8'h00
) (
  input logic              clk,
  input logic              rst_n,
  bcd_time_counter_if.slave bus
);

  typedef enum logic {
    ST_RUN,
    ST_SET
  } state_t;

  state_t     state;
  logic [7:0] hh_q, mm_q, ss_q;
  logic [7:0] hh_n, mm_n, ss_n;
  logic       roll_q, roll_n;
`ifdef TWELVE_HOUR_EN
  logic       pm_q, pm_n;
`endif

  // digit order: ss units, ss tens, mm units,
  // mm tens, hh units, hh tens
  logic [5:0][3:0] dig;
  logic [5:0][3:0] sum;
  logic [5:0]      co;
  logic [5:0]      dok;

  assign dig = {hh_q[7:4], hh_q[3:0],
                mm_q[7:4], mm_q[3:0],
                ss_q[7:4], ss_q[3:0]};

  for (genvar i = 0; i < 6; i++) begin : g_inc
    cla4 u_cla (
      .a   (dig[i]),
      .b   (4'd0),
      .cin (1'b1),
      .sum (sum[i]),
      .cout(co[i])
    );
    // a digit is 0..9 exactly when digit+1 lands in 1..10
    assign dok[i] = !co[i] && (sum[i] <= 4'd10);
  end

  logic s_ok, m_ok, h_ok;

  assign s_ok = dok[0] && dok[1]
             && (ss_q[7:4] <= 4'd5);
  assign m_ok = dok[2] && dok[3]
             && (mm_q[7:4] <= 4'd5);

`ifdef TWELVE_HOUR_EN
  assign h_ok = dok[4] && dok[5]
    && (((hh_q[7:4] == 4'd0) && (hh_q[3:0] != 4'd0))
     || ((hh_q[7:4] == 4'd1) && (hh_q[3:0] <= 4'd2)));
`else
  assign h_ok = dok[4] && dok[5]
    && ((hh_q[7:4] < 4'd2)
     || ((hh_q[7:4] == 4'd2) && (hh_q[3:0] <= 4'd3)));
`endif

  // {wrap, next} for a 00..59 field; illegal input recovers to 00
  function automatic logic [8:0] inc60(
    input logic [7:0] v,
    input logic [3:0] us,
    input logic [3:0] ts,
    input logic       ok
  );
    if (!ok)
      return {1'b0, 8'h00};
    else if (us != 4'd10)
      return {1'b0, v[7:4], us};
    else if (ts == 4'd6)
      return {1'b1, 8'h00};
    else
      return {1'b0, ts, 4'h0};
  endfunction

`ifdef TWELVE_HOUR_EN
  // {pm toggle, next} for 01..12; illegal input recovers to 01
  function automatic logic [8:0] inc_hr(
    input logic [7:0] v,
    input logic [3:0] us,
    input logic [3:0] ts,
    input logic       ok
  );
    if (!ok)
      return {1'b0, 8'h01};
    else if (v == 8'h12)
      return {1'b0, 8'h01};
    else if (v == 8'h11)
      return {1'b1, 8'h12};
    else if (us == 4'd10)
      return {1'b0, ts, 4'h0};
    else
      return {1'b0, v[7:4], us};
  endfunction
`else
  // {wrap, next} for 00..23; illegal input recovers to 00
  function automatic logic [8:0] inc_hr(
    input logic [7:0] v,
    input logic [3:0] us,
    input logic [3:0] ts,
    input logic       ok
  );
    if (!ok)
      return {1'b0, 8'h00};
    else if (v == 8'h23)
      return {1'b1, 8'h00};
    else if (us == 4'd10)
      return {1'b0, ts, 4'h0};
    else
      return {1'b0, v[7:4], us};
  endfunction
`endif

  logic [8:0] s_inc, m_inc, h_inc;
  logic       run_tick, set_bump;

  assign s_inc = inc60(ss_q, sum[0], sum[1], s_ok);
  assign m_inc = inc60(mm_q, sum[2], sum[3], m_ok);
  assign h_inc = inc_hr(hh_q, sum[4], sum[5], h_ok);

  assign run_tick = (state == ST_RUN) && bus.tick_1hz;
  assign set_bump = (state == ST_SET) && bus.set_inc;

  // next time: full carry cascade in RUN, single field in SET
  always_comb begin
    ss_n   = ss_q;
    mm_n   = mm_q;
    hh_n   = hh_q;
    roll_n = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_n   = pm_q;
`endif
    unique case (1'b1)
      run_tick: begin
        ss_n = s_inc[7:0];
        if (s_inc[8]) begin
          mm_n = m_inc[7:0];
          if (m_inc[8]) begin
            hh_n = h_inc[7:0];
`ifdef TWELVE_HOUR_EN
            if (h_inc[8]) begin
              pm_n   = ~pm_q;
              roll_n = pm_q;
            end
`else
            roll_n = h_inc[8];
`endif
          end
        end
      end
      set_bump: begin
        unique case (1'b1)
          (bus.set_sel == 2'd0): ss_n = s_inc[7:0];
          (bus.set_sel == 2'd1): mm_n = m_inc[7:0];
          (bus.set_sel == 2'd2): begin
            hh_n = h_inc[7:0];
`ifdef TWELVE_HOUR_EN
            if (h_inc[8])
              pm_n = ~pm_q;
`endif
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // mode FSM and registered time outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      hh_q   <= INIT_HH;
      mm_q   <= INIT_MM;
      ss_q   <= INIT_SS;
      roll_q <= 1'b0;
`ifdef TWELVE_HOUR_EN
      pm_q   <= 1'b0;
`endif
    end else begin
      state  <= bus.set_mode ? ST_SET : ST_RUN;
      hh_q   <= hh_n;
      mm_q   <= mm_n;
      ss_q   <= ss_n;
      roll_q <= roll_n;
`ifdef TWELVE_HOUR_EN
      pm_q   <= pm_n;
`endif
    end
  end

  assign bus.hh           = hh_q;
  assign bus.mm           = mm_q;
  assign bus.ss           = ss_q;
  assign bus.day_rollover = roll_q;
`ifdef TWELVE_HOUR_EN
  assign bus.pm           = pm_q;
`endif

endmodule
